// File: rtl/tpu_pkg.sv
// Shared types and requantization helper for the accumulator datapath.
// Imported by the drain logic and any other requantizing block.
package tpu_pkg;

    localparam int ACC_W = 32;
    localparam int OUT_W = 16;
    localparam int SHIFT_W = 5;

    localparam logic signed [ACC_W:0] SAT_MAX = 33'sd32767;
    localparam logic signed [ACC_W:0] SAT_MIN = -33'sd32768;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } drain_state_t;

    // Round-half-up right shift in 33 bits, then clamp to int16.
    function automatic logic signed [OUT_W-1:0] sat_round(
        input logic signed [ACC_W-1:0] x,
        input logic [SHIFT_W-1:0] sh
    );
        logic signed [ACC_W:0] xe;
        logic signed [ACC_W:0] half;
        logic signed [ACC_W:0] r;
        xe = {x[ACC_W-1], x};
        half = (ACC_W+1)'(1) << (sh - SHIFT_W'(1));
        if (sh == '0) r = xe;
        else r = (xe + half) >>> sh;
        if (r > SAT_MAX) return SAT_MAX[OUT_W-1:0];
        if (r < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        return r[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/accum_drain_fifo.sv
// Capture FIFO for accumulator rows; push while full is allowed
// only when a pop happens in the same cycle.
module drain_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic do_push;
    logic do_pop;

    assign full = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/accum_drain.sv
// Drains accumulator output pulses through a capture FIFO, requantizes
// each row to int16 pairs and streams it out over valid/ready.
import tpu_pkg::*;

module accum_drain #(
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ROW_W-1:0]    num_rows,
    input  logic [SHIFT_W-1:0]  shift_amt,
    input  logic                acc_valid,
    input  logic [ACC_W-1:0]    acc_col0,
    input  logic [ACC_W-1:0]    acc_col1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                err_overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    drain_state_t state;
    drain_state_t state_n;

    logic [ROW_W-1:0] rows_q;
    logic [ROW_W-1:0] acc_cnt;
    logic [ROW_W-1:0] out_cnt;
    logic [SHIFT_W-1:0] shift_q;
    logic [63:0] head;
    logic full;
    logic empty;
    logic [CW-1:0] count;
    logic take;
    logic push;
    logic load;
    logic xfer;
    logic go;
    logic last_n;
    logic [ROW_W:0] idx;

    drain_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (load),
        .din   ({acc_col1, acc_col0}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_n = state;
        go = (state == IDLE) && start;
        take = (state == RUN) && acc_valid;
        xfer = out_valid && out_ready;
        load = !empty && (!out_valid || out_ready);
        push = take && (!full || load);
        // Index of the row being loaded; dropped rows end the drain early.
        idx = {1'b0, out_cnt} + (ROW_W+1)'(out_valid) + 1'b1;
        last_n = (idx == {1'b0, rows_q})
              || ((state == DRAIN) && (count == CW'(1)));
        unique case (state)
            IDLE: begin
                if (start) state_n = (num_rows == '0) ? DONE : RUN;
            end
            RUN: begin
                if (take && (acc_cnt == rows_q - 1'b1)) state_n = DRAIN;
            end
            DRAIN: begin
                if (empty && !out_valid) state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rows_q <= '0;
            shift_q <= '0;
            acc_cnt <= '0;
            out_cnt <= '0;
            err_overflow <= 1'b0;
        end else begin
            state <= state_n;
            if (go) begin
                rows_q <= num_rows;
                shift_q <= shift_amt;
                acc_cnt <= '0;
                out_cnt <= '0;
                err_overflow <= 1'b0;
            end else begin
                if (take) acc_cnt <= acc_cnt + 1'b1;
                if (xfer) out_cnt <= out_cnt + 1'b1;
                if ((take && !push) || ((state == DRAIN) && acc_valid))
                    err_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data <= {sat_round(head[63:32], shift_q),
                         sat_round(head[31:0], shift_q)};
            out_last <= last_n;
        end else if (xfer) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
